token_ring_fifo: RTL

- Single-clock FIFO of DEPTH cells, parametrised in width and depth.
- Write and read positions are one-hot tokens that circulate around a ring of cells. Each cell holds a data register and a full/empty validity bit.
- Successor to the per-cell token FIFO, used wherever producer and consumer share one clock.
- Adds:
  - global full/empty;
  - programmable almost-full/almost-empty;
  - occupancy count;
  - registered read with valid strobe;
  - sticky overflow/underflow flags.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_ring_cell.sv | 50 +++++
 rtl/token_ring_fifo.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the token-ring FIFO family.
//   - DEFAULT_N_BITS : default data width
//   - cnt_w()        : width of an occupancy counter able to hold 0..depth
//   - tok_rotl()     : rotate a one-hot token left by one inside a ring of
//                      `depth` cells (bit depth-1 wraps to bit 0). Bits at
//                      and above `depth` are always returned as zero, so
//                      callers can size-cast the result down to the ring width.
package fifo_pkg;

  localparam int DEFAULT_N_BITS = 32;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [63:0] tok_rotl(input logic [63:0] tok, input int depth);
    logic [63:0] r;
    r    = '0;
    r[0] = tok[depth-1];
    for (int i = 1; i < 64; i++) begin
      if (i < depth) begin
        r[i] = tok[i-1];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ring_cell.sv
// fifo_ring_cell
//   One storage cell of the token ring: a data register plus a validity bit.
//   Ports:
//     clk     : clock, rising edge
//     reset   : synchronous active-high, clears the valid bit only
//     wr_en   : write data and mark the cell valid
//     rd_en   : mark the cell empty (data is read combinationally by the top)
//     wr_data : data to store
//     data    : stored data
//     valid   : cell holds unread data
module fifo_ring_cell
  import fifo_pkg::*;
#(
  parameter int N_BITS = DEFAULT_N_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [N_BITS-1:0] wr_data,
  output logic [N_BITS-1:0] data,
  output logic              valid
);

  logic [N_BITS-1:0] data_reg;
  logic              valid_reg;

  // Data needs no reset: it is only observable through a valid cell.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_reg <= wr_data;
    end
  end

  // wr_en and rd_en never hit the same cell in one cycle: that would need
  // put_tok == get_tok, which only happens when the ring is full or empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
    end else if (wr_en) begin
      valid_reg <= 1'b1;
    end else if (rd_en) begin
      valid_reg <= 1'b0;
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/token_ring_fifo.sv
// token_ring_fifo
//   Single-clock FIFO built from a ring of DEPTH cells addressed by one-hot
//   write/read tokens. Registered read with a one-cycle valid strobe,
//   occupancy count, programmable almost-full/almost-empty, sticky
//   overflow/underflow.
//   Ports:
//     clk, reset            : clock and synchronous active-high reset
//     en_put, data_put      : put request and data
//     en_get                : get request
//     data_get, valid_get   : registered read data and its update strobe
//     full, empty           : ring completely valid / completely empty
//     almost_full           : count >= AF_LEVEL
//     almost_empty          : count <= AE_LEVEL
//     count                 : occupancy 0..DEPTH
//     put_tok, get_tok      : one-hot write/read positions
//     overflow, underflow   : sticky rejected put / rejected get
module token_ring_fifo
  import fifo_pkg::*;
#(
  parameter int N_BITS   = DEFAULT_N_BITS,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1,
  localparam int CNT_W   = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_put,
  input  logic [N_BITS-1:0] data_put,
  input  logic              en_get,
  output logic [N_BITS-1:0] data_get,
  output logic              valid_get,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic [DEPTH-1:0]  put_tok,
  output logic [DEPTH-1:0]  get_tok,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [CNT_W-1:0] AF_CNT  = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT  = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DEPTH-1:0] TOK_INIT = DEPTH'(1);

  logic [DEPTH-1:0]  put_tok_reg, put_tok_next;
  logic [DEPTH-1:0]  get_tok_reg, get_tok_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [N_BITS-1:0] data_get_reg;
  logic              valid_get_reg;
  logic              overflow_reg, underflow_reg;

  logic [DEPTH-1:0]  cell_valid;
  logic [N_BITS-1:0] cell_data [DEPTH];
  logic [N_BITS-1:0] rd_mux;
  logic              put_ok, get_ok;

  // Status comes straight from the cell valid bits; count tracks the same
  // quantity and must always agree with them.
  assign full   = &cell_valid;
  assign empty  = ~|cell_valid;
  assign put_ok = en_put & ~full;
  assign get_ok = en_get & ~empty;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
      fifo_ring_cell #(
        .N_BITS (N_BITS)
      ) u_cell (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (put_ok & put_tok_reg[gi]),
        .rd_en   (get_ok & get_tok_reg[gi]),
        .wr_data (data_put),
        .data    (cell_data[gi]),
        .valid   (cell_valid[gi])
      );
    end
  endgenerate

  // AND-OR read mux: the token is one-hot, so exactly one cell contributes.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_mux = rd_mux | (cell_data[i] & {N_BITS{get_tok_reg[i]}});
    end
  end

  always_comb begin
    put_tok_next = put_tok_reg;
    get_tok_next = get_tok_reg;
    count_next   = count_reg;
    if (put_ok) begin
      put_tok_next = DEPTH'(tok_rotl(64'(put_tok_reg), DEPTH));
    end
    if (get_ok) begin
      get_tok_next = DEPTH'(tok_rotl(64'(get_tok_reg), DEPTH));
    end
    case ({put_ok, get_ok})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      put_tok_reg   <= TOK_INIT;
      get_tok_reg   <= TOK_INIT;
      count_reg     <= '0;
      data_get_reg  <= '0;
      valid_get_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      put_tok_reg   <= put_tok_next;
      get_tok_reg   <= get_tok_next;
      count_reg     <= count_next;
      valid_get_reg <= get_ok;
      if (get_ok) begin
        data_get_reg <= rd_mux;
      end
      // Decided on pre-edge full/empty: a same-cycle get does not make
      // room for a put, and a same-cycle put does not feed a get.
      if (en_put & full) begin
        overflow_reg <= 1'b1;
      end
      if (en_get & empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign data_get     = data_get_reg;
  assign valid_get    = valid_get_reg;
  assign count        = count_reg;
  assign put_tok      = put_tok_reg;
  assign get_tok      = get_tok_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;
  assign almost_full  = (count_reg >= AF_CNT);
  assign almost_empty = (count_reg <= AE_CNT);

endmodule
